// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbBusyI = 2'd1,
    ArbBusyD = 2'd2
  } arb_state_e;

  localparam int unsigned DefMaxDStreak = 4;
  localparam int unsigned DefTimeout    = 64;

  localparam int unsigned StreakWidth = 4;
  localparam int unsigned WdWidth     = 8;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating busy-cycle counter; flags when the granted access has waited TIMEOUT-1 cycles.
module arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [WdWidth-1:0] Limit = WdWidth'(TIMEOUT - 1);

  logic [WdWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != Limit)) begin
      count_d = count_q + WdWidth'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == Limit);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data access, data first,
// with a streak limit against fetch starvation and a watchdog that turns hangs into bus errors.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = DefMaxDStreak,
  parameter int unsigned TIMEOUT      = DefTimeout
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        bus_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam logic [StreakWidth-1:0] StreakMax = StreakWidth'(MAX_D_STREAK);

  arb_state_e             state_q, state_d;
  logic                   m_req_q, m_req_d;
  logic                   m_we_q, m_we_d;
  logic [31:0]            m_addr_q, m_addr_d;
  logic [31:0]            m_wdata_q, m_wdata_d;
  logic [StreakWidth-1:0] streak_q, streak_d;

  logic busy, done, timed_out, wd_expired;
  logic grant_d, grant_i;

  always_comb begin
    busy      = (state_q != ArbIdle);
    done      = busy && (m_ack || wd_expired);
    // A real ack wins over a simultaneous timeout.
    timed_out = busy && !m_ack && wd_expired;
    grant_d   = (state_q == ArbIdle) && d_req && !(i_req && (streak_q == StreakMax));
    grant_i   = (state_q == ArbIdle) && !grant_d && i_req;
  end

  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    streak_d  = streak_q;
    unique case (state_q)
      ArbIdle: begin
        if (grant_d) begin
          state_d   = ArbBusyD;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (!i_req) begin
            streak_d = '0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + StreakWidth'(1);
          end
        end else if (grant_i) begin
          state_d   = ArbBusyI;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          streak_d  = '0;
        end
      end
      ArbBusyI, ArbBusyD: begin
        if (done) begin
          state_d = ArbIdle;
          m_req_d = 1'b0;
        end
      end
      default: begin
        state_d = ArbIdle;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ArbIdle;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      streak_q  <= '0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      streak_q  <= streak_d;
    end
  end

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (grant_d || grant_i),
    .inc    (busy && !m_ack),
    .expired(wd_expired)
  );

  always_comb begin
    i_ready = (state_q == ArbBusyI) && done;
    d_ready = (state_q == ArbBusyD) && done;
    bus_err = timed_out;
    i_rdata = (i_ready && m_ack) ? m_rdata : '0;
    d_rdata = (d_ready && m_ack) ? m_rdata : '0;
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: priority, streak limit, timeout, async reset, idle behaviour.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ready, d_ready, bus_err;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;

  // 0: no auto ack, 1: zero-wait ack, 2: ack in second m_req cycle
  int unsigned mode;
  logic        ack_force;
  logic        m_req_d1;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) m_req_d1 <= m_req;

  assign m_ack   = ack_force || (mode == 1 && m_req) || (mode == 2 && m_req && m_req_d1);
  assign m_rdata = mem_rdata;

  mem_arbiter #(
    .MAX_D_STREAK(4),
    .TIMEOUT     (64)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_rdata(i_rdata),
    .i_ready(i_ready),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ready(d_ready),
    .bus_err(bus_err),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_ack  (m_ack),
    .m_rdata(m_rdata)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  initial begin
    int pulses, ready_cyc, dcount, early, grants, d_seen;
    logic [31:0] exp_daddr;
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mode = 0; ack_force = 0; mem_rdata = '0;

    // Reset state
    #1;
    check("rst_m_req", 32'(m_req), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_we_wdata", {31'd0, m_we} | m_wdata, 32'd0);
    check("rst_readies", {29'd0, i_ready, d_ready, bus_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // I-only read, memory acks one cycle after m_req rises
    mode = 2; mem_rdata = 32'hDEADBEEF;
    i_req = 1; i_addr = 32'h100;
    pulses = 0; ready_cyc = 0; dcount = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("t1_m_req", 32'(m_req), 32'd1);
        check("t1_m_addr", m_addr, 32'h100);
        check("t1_m_we", 32'(m_we), 32'd0);
      end
      dcount += int'(d_ready);
      if (i_ready) begin
        pulses++;
        ready_cyc = c;
        check("t1_i_rdata", i_rdata, 32'hDEADBEEF);
        i_req = 0;
      end
    end
    check("t1_pulses", 32'(pulses), 32'd1);
    check("t1_latency", 32'(ready_cyc), 32'd2);
    check("t1_no_d_ready", 32'(dcount), 32'd0);

    // Simultaneous: data write first, then instruction
    mode = 1; mem_rdata = 32'h0BADF00D;
    i_req = 1; i_addr = 32'h200;
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h1234;
    @(negedge clk);
    check("t2_d_m_we", 32'(m_we), 32'd1);
    check("t2_d_m_addr", m_addr, 32'h80);
    check("t2_d_m_wdata", m_wdata, 32'h1234);
    check("t2_d_ready", {30'd0, d_ready, i_ready}, 32'b10);
    d_req = 0; d_we = 0;
    @(negedge clk);
    check("t2_gap_idle", {30'd0, m_req, i_ready}, 32'd0);
    @(negedge clk);
    check("t2_i_m_addr", m_addr, 32'h200);
    check("t2_i_m_we_wdata", {31'd0, m_we} | m_wdata, 32'd0);
    check("t2_i_ready", {30'd0, i_ready, d_ready}, 32'b10);
    check("t2_i_rdata", i_rdata, 32'h0BADF00D);
    i_req = 0;
    @(negedge clk);

    // Streak limit: expected order D,D,D,D,I,D,D,D,D,I
    mem_rdata = 32'hCAFE0001;
    i_req = 1; i_addr = 32'h400;
    d_req = 1; d_we = 0; d_addr = 32'h1000; exp_daddr = 32'h1000;
    grants = 0; d_seen = 0;
    for (int c = 0; c < 40 && grants < 10; c++) begin
      @(negedge clk);
      if (d_ready || i_ready) begin
        check("t3_order_is_i", 32'(i_ready), 32'((grants % 5) == 4));
        if (d_ready) begin
          check("t3_d_addr", m_addr, exp_daddr);
          check("t3_d_rdata", d_rdata, 32'hCAFE0001);
          exp_daddr += 4;
          d_addr = exp_daddr;
          d_seen++;
        end else begin
          check("t3_i_addr", m_addr, 32'h400);
        end
        grants++;
      end
    end
    check("t3_grants", 32'(grants), 32'd10);
    check("t3_d_grants", 32'(d_seen), 32'd8);
    i_req = 0; d_req = 0;
    @(negedge clk);

    // Timeout: no ack; ready+bus_err in the 64th cycle of m_req
    mode = 0; mem_rdata = 32'hA5A5A5A5;
    d_req = 1; d_we = 0; d_addr = 32'h40;
    early = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (c == 1) check("t4_m_req_up", 32'(m_req), 32'd1);
      if (c < 64) early += int'(d_ready || bus_err);
    end
    check("t4_no_early", 32'(early), 32'd0);
    check("t4_ready_err", {30'd0, d_ready, bus_err}, 32'b11);
    check("t4_d_rdata", d_rdata, 32'd0);
    d_req = 0;
    @(negedge clk);
    check("t4_m_req_down", 32'(m_req), 32'd0);
    repeat (2) @(negedge clk);
    ack_force = 1;
    #1;
    check("t4_late_ack", {29'd0, i_ready, d_ready, bus_err}, 32'd0);
    @(negedge clk);
    ack_force = 0;
    check("t4_still_idle", 32'(m_req), 32'd0);

    // Async reset while in BUSY_I
    i_req = 1; i_addr = 32'h300;
    @(negedge clk);
    check("t5_busy", {m_addr[30:0], m_req}, {31'h300, 1'b1});
    #2 rst = 1'b1;
    #1;
    check("t5_async_clear", {m_addr[30:0], m_req}, 32'd0);
    check("t5_no_ready", 32'(i_ready), 32'd0);
    @(negedge clk);
    check("t5_no_ready_hold", 32'(i_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_regrant", {m_addr[30:0], m_req}, {31'h300, 1'b1});
    mode = 1; mem_rdata = 32'h5555AAAA;
    #1;
    check("t5_finish", i_rdata, 32'h5555AAAA);
    i_req = 0;
    @(negedge clk);
    mode = 0;

    // Idle quiet with random memory noise
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ack_force = 1'($urandom);
      mem_rdata = $urandom;
      #1;
      check("t6_ctrl", {28'd0, m_req, i_ready, d_ready, bus_err}, 32'd0);
      check("t6_rdata", i_rdata | d_rdata, 32'd0);
    end
    ack_force = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified single-port memory between the fetch stage's instruction port and the memory stage's data port.
- Grants one transaction at a time and drives the memory request/acknowledge handshake.
- Returns read data and a one-cycle ready to the granted requester; the pipeline uses the un-readied request as its stall.
- Data port has priority; a streak limit prevents fetch starvation. A watchdog converts a hung memory access into a bus error.

Parameters:
- MAX_D_STREAK, 4, consecutive data grants allowed while i_req is pending before one instruction grant is forced (1..15).
- TIMEOUT, 64, cycles without m_ack before the access is abandoned and flagged (2..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  instruction read request; held until i_ready
- i_addr  in  32  instruction address (word aligned)
- i_rdata  out  32  instruction data, valid with i_ready
- i_ready  out  1  instruction transaction complete (one-cycle pulse)
- d_req  in  1  data request; held until d_ready
- d_we  in  1  data write enable
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid with d_ready
- d_ready  out  1  data transaction complete (one-cycle pulse)
- bus_err  out  1  granted access timed out; pulses with that port's ready
- m_req  out  1  memory request, registered
- m_we  out  1  memory write enable, registered
- m_addr  out  32  memory address, registered
- m_wdata  out  32  memory write data, registered
- m_ack  in  1  memory completion, one cycle
- m_rdata  in  32  memory read data, valid with m_ack

Behaviour:
- Reset (async) clears all registered state immediately:
  - state=IDLE; m_req=0, m_we=0, m_addr=0, m_wdata=0.
  - streak=0, watchdog=0.
  - Outputs i_ready, d_ready and bus_err are 0.
  - An in-flight memory access is abandoned; memory must discard it.
- FSM states are IDLE, BUSY_I and BUSY_D.
- IDLE:
  - If d_req and not (i_req and streak==MAX_D_STREAK): grant D. m_req<=1, m_we<=d_we, m_addr<=d_addr, m_wdata<=d_wdata. Go to BUSY_D.
  - Else if i_req: grant I. m_req<=1, m_we<=0, m_addr<=i_addr, m_wdata<=0. Go to BUSY_I.
  - Else stay in IDLE with m_req=0.
- In BUSY_x, m_req, m_we, m_addr and m_wdata stay stable until completion. Completion is either m_ack=1 or watchdog==TIMEOUT-1.
- Completion on m_ack, same cycle:
  - x_ready=1 and x_rdata=m_rdata, combinational pass-through.
  - For a write, d_rdata=m_rdata is don't-care.
  - Next edge: m_req<=0, go to IDLE.
- Completion on timeout, same cycle:
  - x_ready=1, bus_err=1, x_rdata=0.
  - Next edge: m_req<=0, go to IDLE.
  - A late m_ack arriving in IDLE is ignored.
- m_ack arriving while m_req=0 is ignored.
- Watchdog:
  - Clears on every grant.
  - Increments each BUSY cycle without m_ack.
  - Saturates; it never wraps.
- Streak counter:
  - Increments on a D grant made while i_req=1, saturating at MAX_D_STREAK.
  - Clears on any I grant.
  - Clears on a D grant made while i_req=0.
- A requester sees ready at a clock edge and may drop or change its request at that edge. The FSM is in IDLE the following cycle and samples the new request values.
- Back-to-back transactions therefore complete at most once every 2 cycles per grant.
- Latency:
  - Request sampled in IDLE at cycle 0; m_req high in cycle 1.
  - With m_ack in cycle 1, ready is in cycle 1. Minimum latency is 2 cycles from request to ready.
- Request inputs are ignored while BUSY. Changing a held request's address or data before ready is illegal (assertion in the bench).
- x_rdata is 0 whenever x_ready=0.
- i_ready and d_ready are never high together.

Decomposition:
- Shared package (defines.v) holds:
  - State encoding ARB_IDLE=2'd0, ARB_BUSY_I=2'd1, ARB_BUSY_D=2'd2.
  - Default MAX_D_STREAK and TIMEOUT constants.
- Sub-module arb_watchdog holds the saturating counter with clear and increment controls and a TIMEOUT-compare output. Everything else is inline.

Test Plan:
- I-only request: i_req=1 with i_addr=0x100, memory acks 1 cycle after m_req with m_rdata=0xDEADBEEF. Required: m_addr=0x100, m_we=0, i_ready pulses once, i_rdata=0xDEADBEEF, d_ready stays 0.
- Simultaneous requests: i_req=1 with i_addr=0x200 and d_req=1 with d_we=1, d_addr=0x80, d_wdata=0x1234, zero-wait memory. Required:
  - The data write goes first: m_we=1, m_addr=0x80, m_wdata=0x1234.
  - d_ready follows, then the instruction grant with m_addr=0x200.
- Starvation limit: with MAX_D_STREAK=4, d_req and i_req both held high continuously and d_addr incremented by 4 on each d_ready. Required: grant order D,D,D,D,I,D,D,D,D,I…
- Timeout: d_req=1 with d_we=0 and m_ack held 0. Required:
  - Exactly TIMEOUT=64 cycles after m_req rises, d_ready=1, bus_err=1, d_rdata=0.
  - Then m_req=0.
  - An m_ack injected 3 cycles later produces no ready.
- Reset mid-operation: rst asserted asynchronously (between clock edges) while in BUSY_I with m_req=1. Required:
  - m_req=0 before the next clock edge.
  - No i_ready.
  - After release with i_req still high, a fresh grant with m_req high 1 cycle later.
- Idle quiet: no requests for 20 cycles with random m_ack/m_rdata toggling. Required: m_req=0, i_ready=d_ready=bus_err=0, i_rdata=d_rdata=0 throughout.
